// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between an instruction-fetch port and a data port.
// Data wins ties until the fetch has been starved STARVE_LIMIT times; a hung RAM is cut off after TIMEOUT cycles.
module mem_arbiter #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [DATA_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [DATA_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,
    output logic              bus_err_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [DATA_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    input  logic              ram_ack_i
);

    localparam int unsigned SC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int unsigned WT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_LIMIT);
    localparam logic [WT_W-1:0] WT_LAST = WT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              bus_err_q, bus_err_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic [WT_W-1:0]   wait_q, wait_d;

    logic              grant_if;
    logic              finish;
    logic              timed_out;
    logic [DATA_W-1:0] rd_val;

    // Next-state: arbitration in IDLE, ack/timeout completion in BUSY.
    always_comb begin
        state_d     = state_q;
        ram_en_d    = ram_en_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        if_rdata_d  = '0;
        dm_rdata_d  = '0;
        bus_err_d   = 1'b0;
        starve_d    = starve_q;
        wait_d      = wait_q;
        grant_if    = 1'b0;
        finish      = 1'b0;
        timed_out   = 1'b0;
        rd_val      = '0;

        unique case (state_q)
            IDLE: begin
                // No grant in the cycle a completion pulse is on the outputs.
                if (!if_ready_q && !dm_ready_q && (if_req_i || dm_req_i)) begin
                    grant_if = if_req_i && (!dm_req_i || (starve_q == SC_MAX));
                    ram_en_d = 1'b1;
                    wait_d   = '0;
                    if (grant_if) begin
                        state_d     = IF_BUSY;
                        ram_we_d    = 1'b0;
                        ram_addr_d  = if_addr_i;
                        ram_wdata_d = '0;
                        starve_d    = '0;
                    end else begin
                        state_d     = DM_BUSY;
                        ram_we_d    = dm_we_i;
                        ram_addr_d  = dm_addr_i;
                        ram_wdata_d = dm_wdata_i;
                        if (!if_req_i) begin
                            starve_d = '0;
                        end else if (starve_q != SC_MAX) begin
                            starve_d = starve_q + SC_W'(1);
                        end
                    end
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (ram_ack_i) begin
                    finish = 1'b1;
                end else begin
                    wait_d = wait_q + WT_W'(1);
                    if (wait_q == WT_LAST) begin
                        finish    = 1'b1;
                        timed_out = 1'b1;
                    end
                end
                if (finish) begin
                    state_d   = IDLE;
                    ram_en_d  = 1'b0;
                    ram_we_d  = 1'b0;
                    bus_err_d = timed_out;
                    rd_val    = (timed_out || ram_we_q) ? '0 : ram_rdata_i;
                    if (state_q == IF_BUSY) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = rd_val;
                    end else begin
                        dm_ready_d = 1'b1;
                        dm_rdata_d = rd_val;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            bus_err_q   <= 1'b0;
            starve_q    <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            bus_err_q   <= bus_err_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
        end
    end

    assign ram_en_o    = ram_en_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign if_ready_o  = if_ready_q;
    assign dm_ready_o  = dm_ready_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign bus_err_o   = bus_err_q;

endmodule
